button_conditioner: RTL

Parametrised N-channel push-button front end for the PixelPilot game: synchronises raw board buttons, debounces them, and produces clean level, press, release and auto-repeat strobes. It sits between the board pins (`btn_up`, `btn_down`, `btn_left`, `btn_right`, plus any added buttons) and the sprite/game logic in `game_top`. Held buttons generate repeat strobes, so a held direction moves the sprite smoothly. All channels are independent and identical.

---
 rtl/button_pkg.sv | 31 +++
 rtl/button_chan.sv | 115 +++++++++++
 rtl/button_conditioner.sv | 59 +++++
 3 files changed

// File: rtl/button_pkg.sv
// ============================================================================
// Module : button_pkg
// Brief  : Shared FSM encoding and counter-width helpers for button_conditioner
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    localparam int DEF_N_BTN           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 30_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_chan.sv
// ============================================================================
// Module : button_chan
// Brief  : One button channel: 2-flop synchroniser, debounce, hold/repeat FSM
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_chan
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic press_next_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(max_of(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DW-1:0] c_DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] c_DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] c_PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    btn_state_e    state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    logic w_diff, w_accept, w_rise, w_fall;

    assign w_diff   = sync2_q ^ level_q;
    assign w_accept = w_diff && (deb_cnt_q == c_DEB_LAST);
    assign w_rise   = w_accept && sync2_q;
    assign w_fall   = w_accept && !sync2_q;

    assign level_d   = level_q ^ w_accept;
    assign deb_cnt_d = (!w_diff || w_accept) ? '0 : deb_cnt_q + DW'(1);

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rpt_cnt_d = '0;
                if (w_rise) begin
                    press_d = 1'b1;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // A falling accept outranks any repeat terminal count this cycle.
                if (w_fall) begin
                    release_d = 1'b1;
                    rpt_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (!repeat_en_i) begin
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == ((state_q == ST_DELAY) ? c_DLY_LAST : c_PER_LAST)) begin
                    press_d   = 1'b1;
                    rpt_cnt_d = '0;
                    state_d   = ST_REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RW'(1);
                end
            end
            default: begin
                rpt_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
            rpt_cnt_q <= '0;
            state_q   <= ST_IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign press_next_o = press_d;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module : button_conditioner
// Brief  : N-channel push-button front end with debounce and auto-repeat
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    logic [N_BTN-1:0] w_press_next;
    logic             any_press_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk_i        (clk),
            .rst_ni       (reset_n),
            .btn_raw_i    (btn_raw[i]),
            .repeat_en_i  (repeat_en[i]),
            .level_o      (btn_level[i]),
            .press_o      (btn_press[i]),
            .release_o    (btn_release[i]),
            .press_next_o (w_press_next[i])
        );
    end

    // Built from the channels' next-press terms so it lands with btn_press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |w_press_next;
        end
    end

    assign any_press = any_press_q;

endmodule

`default_nettype wire
